// File: rtl/display_scan_ctrl.sv
// Multiplexed 4-digit 7-segment scan controller.
// Each digit gets DEAD_CYCLES all-off clocks followed by DIV_CYCLES of drive.
// A new value goes into a one-entry pending slot. It is copied to the display
// register only at a frame boundary, or straight away while scanning is
// disabled, so a value is never shown half old and half new within a frame.
//
// state | meaning
// BLANK | all anodes off, dec_in = 4'hF; dead time before the next digit
// DRIVE | anode of digit_idx on, dec_in = decoded digit (or 4'hF if blanked/invalid)
module display_scan_ctrl #(
  parameter int DIV_CYCLES  = 50000,
  parameter int DEAD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        blank_lz,
  input  logic        load_valid,
  input  logic [15:0] load_data,
  output logic        load_ready,
  output logic [3:0]  dec_in,
  output logic [3:0]  anode_n,
  output logic [1:0]  digit_idx,
  output logic        frame_done
);

  localparam int CNT_MAX = (DIV_CYCLES > DEAD_CYCLES) ? DIV_CYCLES : DEAD_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV_CYCLES - 1);
  localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYCLES - 1);

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    idx_nxt;
  logic [15:0]   disp, disp_nxt;
  logic [15:0]   pend, pend_nxt;
  logic          ready_nxt;
  logic [3:0]    anode_nxt;
  logic [3:0]    dec_nxt;
  logic          fd_nxt;

  // Code sent to the decoder for one digit. A digit above 9 is shown blank.
  // With leading-zero blanking, a digit above position 0 is blanked when it
  // and every digit to its left are zero. Digit 0 is never blanked.
  function automatic logic [3:0] digit_code(input logic [15:0] val,
                                            input logic [1:0]  sel,
                                            input logic        lz);
    logic [3:0] nib;
    logic       upper_zero;
    nib        = val[3:0];
    upper_zero = 1'b0;
    case (sel)
      2'd0: begin nib = val[3:0];   upper_zero = 1'b0;                end
      2'd1: begin nib = val[7:4];   upper_zero = (val[15:4]  == 12'h0); end
      2'd2: begin nib = val[11:8];  upper_zero = (val[15:8]  == 8'h0);  end
      default: begin nib = val[15:12]; upper_zero = (val[15:12] == 4'h0); end
    endcase
    if (lz && upper_zero) begin
      return 4'hF;
    end else if (nib > 4'd9) begin
      return 4'hF;
    end
    return nib;
  endfunction

  // Next-state, load handshake and next-output logic.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = digit_idx;
    disp_nxt  = disp;
    pend_nxt  = pend;
    ready_nxt = load_ready;
    anode_nxt = 4'b1111;
    dec_nxt   = 4'hF;
    fd_nxt    = 1'b0;

    // Pending slot. The copy to the display happens in the frame_done cycle,
    // which is a BLANK cycle, so the whole next frame shows the new value.
    // The slot is full in that cycle, so a new load cannot coincide with the copy.
    if (!load_ready && (!en || frame_done)) begin
      disp_nxt  = pend;
      ready_nxt = 1'b1;
    end else if (load_valid && load_ready) begin
      pend_nxt  = load_data;
      ready_nxt = 1'b0;
    end

    if (!en) begin
      state_nxt = BLANK;
      cnt_nxt   = '0;
      idx_nxt   = 2'd0;
    end else begin
      case (state)
        BLANK: begin
          if (cnt == DEAD_LAST) begin
            state_nxt = DRIVE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        default: begin
          if (cnt == DIV_LAST) begin
            state_nxt = BLANK;
            cnt_nxt   = '0;
            idx_nxt   = digit_idx + 2'd1;
            fd_nxt    = (digit_idx == 2'd3);
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      endcase
    end

    // Outputs are registered, so they are computed from the values the state
    // will hold next. This uses disp_nxt so that a copy made on the last blank
    // cycle is already visible when drive starts (DEAD_CYCLES = 1).
    if (state_nxt == DRIVE) begin
      anode_nxt = ~(4'b0001 << idx_nxt);
      dec_nxt   = digit_code(disp_nxt, idx_nxt, blank_lz);
    end
  end

  // State, data and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= BLANK;
      cnt        <= '0;
      digit_idx  <= 2'd0;
      disp       <= 16'h0000;
      pend       <= 16'h0000;
      load_ready <= 1'b1;
      anode_n    <= 4'b1111;
      dec_in     <= 4'hF;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      digit_idx  <= idx_nxt;
      disp       <= disp_nxt;
      pend       <= pend_nxt;
      load_ready <= ready_nxt;
      anode_n    <= anode_nxt;
      dec_in     <= dec_nxt;
      frame_done <= fd_nxt;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl. The reference model tracks the
// position within the scan timeline as an integer. Expected outputs are
// derived from that position with division and modulo arithmetic.
module tb_display_scan_ctrl;

  localparam int DIV  = 4;
  localparam int DEAD = 2;
  localparam int SLOT = DIV + DEAD;
  localparam int PER  = 4 * SLOT;

  logic        clk;
  logic        rst;
  logic        en;
  logic        blank_lz;
  logic        load_valid;
  logic [15:0] load_data;
  logic        load_ready;
  logic [3:0]  dec_in;
  logic [3:0]  anode_n;
  logic [1:0]  digit_idx;
  logic        frame_done;

  display_scan_ctrl #(.DIV_CYCLES(DIV), .DEAD_CYCLES(DEAD)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .blank_lz   (blank_lz),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .dec_in     (dec_in),
    .anode_n    (anode_n),
    .digit_idx  (digit_idx),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int          pos;        // cycles since the scan (re)started; 0 = first blank cycle
  logic [15:0] m_disp;
  logic [15:0] m_pend;
  bit          m_pv;       // pending slot full
  logic        m_blz;      // blank_lz as sampled at the previous edge
  bit          armed;      // set once the model has seen a reset edge
  int          fd_count;
  int          first_fd_pos;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_code(input logic [15:0] val, input int d, input logic lz);
    int nib;
    int upper;
    nib   = (val >> (4 * d)) & 15;
    upper = val >> (4 * d);
    if (lz && d > 0 && upper == 0) return 4'hF;
    if (nib > 9) return 4'hF;
    return 4'(nib);
  endfunction

  // Compare the outputs of the current cycle against the model
  task automatic check_outputs();
    int  p;
    int  d;
    int  w;
    bit  drv;
    bit  fd;
    p   = pos % PER;
    d   = p / SLOT;
    w   = p % SLOT;
    drv = (w >= DEAD);
    fd  = (pos > 0) && (p == 0);
    chk("anode_n",    {28'h0, anode_n},    drv ? {28'h0, ~(4'b0001 << d)} : 32'hF);
    chk("dec_in",     {28'h0, dec_in},     drv ? {28'h0, exp_code(m_disp, d, m_blz)} : 32'hF);
    chk("digit_idx",  {30'h0, digit_idx},  32'(d));
    chk("frame_done", {31'h0, frame_done}, {31'h0, fd});
    chk("load_ready", {31'h0, load_ready}, {31'h0, !m_pv});
    chk("anode_onehot", 32'($countones(~anode_n) <= 1), 32'h1);
    if (fd) begin
      fd_count++;
      if (first_fd_pos < 0) first_fd_pos = pos;
    end
  endtask

  // Advance the model across the coming edge with the inputs now applied
  task automatic model_step();
    bit fd;
    if (rst) begin
      pos    = 0;
      m_disp = 16'h0000;
      m_pend = 16'h0000;
      m_pv   = 1'b0;
      armed  = 1'b1;
    end else begin
      fd = (pos > 0) && (pos % PER == 0);
      if (m_pv && (!en || fd)) begin
        m_disp = m_pend;
        m_pv   = 1'b0;
      end else if (load_valid && !m_pv) begin
        m_pend = load_data;
        m_pv   = 1'b1;
      end
      pos = en ? pos + 1 : 0;
    end
    m_blz = blank_lz;
  endtask

  task automatic cycle(input logic r, input logic e, input logic lz,
                       input logic lv, input logic [15:0] ld);
    rst        = r;
    en         = e;
    blank_lz   = lz;
    load_valid = lv;
    load_data  = ld;
    @(negedge clk);
    if (armed) check_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input logic e, input logic lz);
    for (int i = 0; i < n; i++) cycle(1'b0, e, lz, 1'b0, 16'h0);
  endtask

  function automatic logic [15:0] rnd_val();
    logic [15:0] v;
    v = '0;
    for (int k = 0; k < 4; k++) begin
      if ($urandom_range(1, 0) == 1) v[4*k +: 4] = 4'($urandom_range(15, 0));
    end
    return v;
  endfunction

  initial begin
    logic e;
    logic lz;
    int   off_left;
    armed        = 1'b0;
    pos          = 0;
    m_disp       = '0;
    m_pend       = '0;
    m_pv         = 1'b0;
    m_blz        = 1'b0;
    fd_count     = 0;
    first_fd_pos = -1;
    rst = 1'b1; en = 1'b0; blank_lz = 1'b0; load_valid = 1'b0; load_data = '0;
    @(posedge clk);
    #1;

    // Reset, then free-running scan of the reset value
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
    run(30, 1'b1, 1'b0);
    chk("first_frame_done_pos", 32'(first_fd_pos), 32'(PER));

    // Mid-frame load shown from the following frame
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 16'h1234);
    run(60, 1'b1, 1'b0);

    // Leading-zero blanking cases and an invalid digit
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 16'h0007);
    run(50, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 16'h0000);
    run(50, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 16'h0100);
    run(50, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 16'h00A5);
    run(50, 1'b1, 1'b0);

    // Disable during digit 2 drive, then re-enable
    while (pos % PER != 2 * SLOT + DEAD + 1) cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    run(3, 1'b0, 1'b0);
    run(10, 1'b1, 1'b0);

    // Reset while driving with a load pending; that value must be discarded
    while (pos % PER != SLOT + DEAD + 1) cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 16'h9876);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
    run(60, 1'b1, 1'b0);

    // Randomized traffic
    e = 1'b1;
    lz = 1'b0;
    off_left = 0;
    for (int i = 0; i < 6000; i++) begin
      logic r;
      logic lv;
      r = ($urandom_range(599, 0) == 0);
      if (off_left > 0) begin
        off_left--;
        e = (off_left == 0);
      end else if ($urandom_range(79, 0) == 0) begin
        off_left = $urandom_range(4, 1);
        e = 1'b0;
      end
      if ($urandom_range(99, 0) == 0) lz = ~lz;
      lv = ($urandom_range(7, 0) == 0);
      cycle(r, e, lz, lv, rnd_val());
    end
    run(30, 1'b1, 1'b0);

    chk("frame_done_seen", 32'(fd_count > 100), 32'h1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 SHALL have parameter DIV_CYCLES, default 50000: clocks each digit is driven (>=1).
REQ-002 SHALL have parameter DEAD_CYCLES, default 4: all-off clocks before each digit (>=1).
REQ-003 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port en, input, 1: scan enable.
REQ-006 SHALL have port blank_lz, input, 1: leading-zero blanking enable.
REQ-007 SHALL have port load_valid, input, 1: new display value offered.
REQ-008 SHALL have port load_data, input, 16: four BCD digits; [3:0] digit0 (rightmost) through [15:12] digit3.
REQ-009 SHALL have port load_ready, output, 1: pending-value slot empty.
REQ-010 SHALL have port dec_in, output, 4: code to the shared 7-segment decoder; 4'hF means blank (decoder default = all segments off).
REQ-011 SHALL have port anode_n, output, 4: active-low digit enables; bit i drives digit i.
REQ-012 SHALL have port digit_idx, output, 2: digit currently scanned.
REQ-013 SHALL have port frame_done, output, 1: one-cycle pulse at end of each frame.

Function
REQ-014 SHALL implement FSM {BLANK, DRIVE} with a cycle counter and a 2-bit digit index; all outputs registered.
REQ-015 BLANK SHALL hold anode_n=4'b1111 and dec_in=4'hF for DEAD_CYCLES cycles, then enter DRIVE.
REQ-016 DRIVE SHALL hold anode_n bit digit_idx low (others high) for DIV_CYCLES cycles, then enter BLANK with digit_idx incremented mod 4 (3 wraps to 0).
REQ-017 frame_done SHALL pulse high for exactly one cycle on the first BLANK cycle after digit3's DRIVE ends; frame period = 4*(DEAD_CYCLES+DIV_CYCLES).
REQ-018 In DRIVE, dec_in SHALL equal display digit[digit_idx] if that digit is <=9; otherwise it SHALL be 4'hF (anode still enabled).
REQ-019 With blank_lz=1, digit i (i=1..3) SHALL output 4'hF when it and all higher digits are zero; digit0 SHALL never be blanked.
REQ-020 A load SHALL be accepted on a clock edge with load_valid=1 and load_ready=1; load_data is captured into a pending register and load_ready is 0 from the next cycle.
REQ-021 A pending value SHALL transfer to the display register at the frame boundary (cycle frame_done is high), or on the next cycle if en=0; load_ready SHALL return to 1 the cycle after transfer.
REQ-022 A value accepted in cycle t SHALL NOT be displayed before the first frame boundary strictly after t; no value is ever dropped or torn across a frame.
REQ-023 en=0 SHALL force, from the next cycle: BLANK, counter 0, digit_idx 0, anode_n=4'b1111, dec_in=4'hF, frame_done 0.
REQ-024 Re-asserting en SHALL restart the scan at digit0 after DEAD_CYCLES blank cycles.
REQ-025 Two anode_n bits SHALL never be low simultaneously in any cycle.

Reset
REQ-026 rst=1 SHALL, on the next edge: BLANK, counter 0, digit_idx 0, display register 16'h0000, pending register cleared, load_ready 1, anode_n 4'b1111, dec_in 4'hF, frame_done 0.
REQ-027 rst SHALL override en and load_valid, and an in-flight pending load SHALL be discarded.

Verification (DIV_CYCLES=4, DEAD_CYCLES=2)
REQ-028 Release rst, en=1, no load -> anode_n: 1111 x2, 1110 x4, 1111 x2, 1101 x4, ..., 0111 x4; frame_done pulses 24 cycles after the first BLANK cycle; dec_in 0 during every DRIVE.
REQ-029 Load 16'h1234 in mid-frame -> load_ready 0 until the boundary; following frame dec_in 4,3,2,1 with anode_n 1110,1101,1011,0111; load_ready back to 1.
REQ-030 blank_lz=1, value 16'h0007 -> dec_in 7,F,F,F; value 16'h0000 -> 0,F,F,F; value 16'h0100 -> 0,0,1,F.
REQ-031 Value 16'h00A5 -> digit1 dec_in 4'hF with anode_n 1101 low; digit0 shows 5.
REQ-032 en=0 during digit2 DRIVE -> next cycle anode_n 1111, digit_idx 0; en=1 -> 2 blank cycles then anode_n 1110.
REQ-033 rst during DRIVE with a pending load -> next cycle all reset values; the old pending value never appears on dec_in.
